// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// state encoding and the bit-counter width derivation.
package serial_sub_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // One extra bit keeps WIDTH=1 from collapsing the counter to zero bits.
   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full-subtractor cell: diff = a - b - bin, bout set when a borrow
// is needed. Purely combinational; reused once per bit by the controller.
module serial_sub_ctrl_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: feeds one shared 1-bit cell
// LSB first, then publishes diff/bout with a one-cycle done pulse.
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int               CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] d_sh_r;
   logic [WIDTH-1:0] d_next_s;
   logic             brw_r;
   logic [CNT_W-1:0] cnt_r;
   logic             cell_diff_s;
   logic             cell_bout_s;

   serial_sub_ctrl_cell u_cell (
      .a    (a_sh_r[0]),
      .b    (b_sh_r[0]),
      .bin  (brw_r),
      .diff (cell_diff_s),
      .bout (cell_bout_s)
   );

   // New result bits enter at the MSB so the LSB-first stream lands aligned.
   generate
      if (WIDTH == 1) begin : g_w1
         assign d_next_s = cell_diff_s;
      end else begin : g_wn
         assign d_next_s = {cell_diff_s, d_sh_r[WIDTH-1:1]};
      end
   endgenerate

   // Controller state, operand/result shift registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         a_sh_r  <= '0;
         b_sh_r  <= '0;
         d_sh_r  <= '0;
         brw_r   <= 1'b0;
         cnt_r   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  brw_r   <= bin;
                  cnt_r   <= '0;
                  busy    <= 1'b1;
                  state_r <= S_RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_RUN: begin
               d_sh_r <= d_next_s;
               a_sh_r <= a_sh_r >> 1;
               b_sh_r <= b_sh_r >> 1;
               brw_r  <= cell_bout_s;
               cnt_r  <= cnt_r + CNT_W'(1'b1);
               if (cnt_r == CNT_LAST) begin
                  diff    <= d_next_s;
                  bout    <= cell_bout_s;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= S_DONE;
               end else begin
                  busy    <= 1'b1;
                  state_r <= S_RUN;
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule
